hada_op_arbiter: RTL and testbench
==================================

HADA_OP_ARBITER -- requirements
Module: hada_op_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter IDW, default $clog2(NREQ), giving the requester-ID width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester request valid.
REQ-006 SHALL have port req_ready, output, NREQ, per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_op, input, NREQ x 2, opcode: 0 ABS, 1 SIGNUM, 2 SIGNUMU, 3 CONS.
REQ-008 SHALL have port req_width, input, NREQ x 2, operand width: 0 = 8, 1 = 16, 2 = 32, 3 = 64 bits.
REQ-009 SHALL have port req_data, input, NREQ x 64, operand; only the low width bits are significant.
REQ-010 SHALL have port rsp_valid, output, 1, result valid.
REQ-011 SHALL have port rsp_ready, input, 1, result consumer accept.
REQ-012 SHALL have port rsp_id, output, IDW, index of the requester owning the result.
REQ-013 SHALL have port rsp_data, output, 64, result extended to 64 bits.

Function
REQ-014 SHALL time-share one operator unit among NREQ requesters with a round-robin arbiter.
REQ-015 SHALL grant the first requester with req_valid high, searching from pointer rr_ptr upward modulo NREQ.
REQ-016 SHALL update rr_ptr to (granted index + 1) mod NREQ only on an accepted transfer (req_valid & req_ready); rr_ptr SHALL hold otherwise.
REQ-017 SHALL run a two-state FSM: EMPTY (no result held) and FULL (result held, rsp_valid = 1).
REQ-018 SHALL assert req_ready[grant] combinationally when state is EMPTY, or when state is FULL and rsp_ready = 1 (same-cycle drain and refill).
REQ-019 SHALL deassert all req_ready bits when state is FULL and rsp_ready = 0; the held result, rsp_id and rsp_data SHALL stay stable.
REQ-020 SHALL produce a result with a latency of 1 cycle: a request accepted at edge N gives rsp_valid = 1 after edge N.
REQ-021 SHALL go FULL->EMPTY on rsp_ready with no new accept, EMPTY->FULL on accept, and stay FULL on a simultaneous drain and accept.
REQ-022 SHALL compute ABS as a two's-complement absolute value at the selected width, sign-extended to 64; the most negative value wraps to itself (8-bit 0x80 -> 0xFFFF_FFFF_FFFF_FF80).
REQ-023 SHALL compute SIGNUM on the signed operand, returning +1, 0 or -1 sign-extended to 64.
REQ-024 SHALL compute SIGNUMU on the unsigned operand, returning 0 for zero and 1 otherwise, zero-extended.
REQ-025 SHALL compute CONS by truncating to the selected width and sign-extending to 64.
REQ-026 SHALL ignore operand bits above the selected width for every opcode.
REQ-027 SHALL leave the arbitration outcome unaffected by req_valid bits that fall while req_ready is low; no fairness credit is kept.

Reset
REQ-028 SHALL, on rst_n low, set immediately and asynchronously: state EMPTY, rsp_valid 0, rsp_id 0, rsp_data 0, rr_ptr 0.
REQ-029 SHALL discard any held result when reset is asserted mid-operation, without producing a response.
REQ-030 SHALL allow the first accept on the first rising clk edge after rst_n deasserts.

Structure
REQ-031 SHALL take the opcode enum (op_t) and width enum (width_t) from the shared package hada, so that requesters use the same encodings.
REQ-032 SHALL place the combinational operator in sub-module hada_op_unit (op, width, data -> 64-bit result), reusing the package abs/signum/cons semantics.
REQ-033 SHALL keep the arbiter, rr_ptr and the FSM/result register in hada_op_arbiter.

Verification
REQ-034 Bench SHALL check: reset, then req0 ABS, width 8, data 0xFB -> rsp_valid next cycle, rsp_id 0, rsp_data 5.
REQ-035 Bench SHALL check: all 4 requesters valid every cycle, rsp_ready = 1 -> grants in order 0,1,2,3,0 and one result per cycle.
REQ-036 Bench SHALL check: rsp_ready = 0 for 3 cycles while FULL -> req_ready all 0 and rsp_data stable; on rsp_ready = 1, drain and refill happen in the same cycle.
REQ-037 Bench SHALL check: boundary values ABS width 8 0x80 -> 0xFF..80; SIGNUM width 16 0x8000 -> all-ones; SIGNUMU width 64 0 -> 0; CONS width 32 0x1_8000_0000 -> 0xFFFF_FFFF_8000_0000.
REQ-038 Bench SHALL check: req2 alone with rr_ptr = 3 -> grant 2 and rr_ptr becomes 3.
REQ-039 Bench SHALL check: rst_n pulsed low while FULL -> rsp_valid drops immediately and no stale result appears after reset.

Source files
------------

// File: rtl/hada_pkg.sv
// Shared encodings and scalar operator semantics for the hada operator unit.
// Requesters import this package so opcode/width encodings stay in one place.
package hada;

  typedef enum logic [1:0] {
    OP_ABS     = 2'd0,
    OP_SIGNUM  = 2'd1,
    OP_SIGNUMU = 2'd2,
    OP_CONS    = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    W_8  = 2'd0,
    W_16 = 2'd1,
    W_32 = 2'd2,
    W_64 = 2'd3
  } width_t;

  function automatic logic [63:0] cons_w(input logic [63:0] d, input width_t w);
    case (w)
      W_8:     return {{56{d[7]}}, d[7:0]};
      W_16:    return {{48{d[15]}}, d[15:0]};
      W_32:    return {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] zext_w(input logic [63:0] d, input width_t w);
    case (w)
      W_8:     return {56'd0, d[7:0]};
      W_16:    return {48'd0, d[15:0]};
      W_32:    return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Negating the sign-extended value and re-truncating makes the most
  // negative value wrap to itself at the selected width.
  function automatic logic [63:0] abs_w(input logic [63:0] d, input width_t w);
    logic [63:0] s;
    s = cons_w(d, w);
    return cons_w(s[63] ? -s : s, w);
  endfunction

  function automatic logic [63:0] signum_s(input logic [63:0] d, input width_t w);
    logic [63:0] s;
    s = cons_w(d, w);
    if (s == 64'd0) return 64'd0;
    else if (s[63]) return '1;
    else return 64'd1;
  endfunction

  function automatic logic [63:0] signum_u(input logic [63:0] d, input width_t w);
    return (zext_w(d, w) != 64'd0) ? 64'd1 : 64'd0;
  endfunction

endpackage

// File: rtl/hada_op_unit.sv
// Combinational scalar operator: applies one opcode at one operand width,
// producing a 64-bit extended result.
module hada_op_unit
  import hada::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  width,
  input  logic [63:0] data,
  output logic [63:0] result
);

  op_t    op_e;
  width_t width_e;

  assign op_e    = op_t'(op);
  assign width_e = width_t'(width);

  always_comb begin
    result = '0;
    case (op_e)
      OP_ABS:     result = abs_w(data, width_e);
      OP_SIGNUM:  result = signum_s(data, width_e);
      OP_SIGNUMU: result = signum_u(data, width_e);
      OP_CONS:    result = cons_w(data, width_e);
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/hada_op_arbiter.sv
// Round-robin time-sharing of one hada_op_unit among NREQ requesters with a
// single-entry result register (1-cycle latency, same-cycle drain/refill).
//   state | meaning
//   EMPTY | no result held, any granted request is accepted
//   FULL  | result held on rsp_*, accept only if rsp_ready drains it
module hada_op_arbiter
  import hada::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [2*NREQ-1:0]   req_width,
  input  logic [64*NREQ-1:0]  req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [63:0]         rsp_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_next;
  logic           found;
  logic           accept;
  logic [63:0]    op_result;
  int             idx;

  logic [1:0]     op_arr    [NREQ];
  logic [1:0]     width_arr [NREQ];
  logic [63:0]    data_arr  [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i]    = req_op[2*i +: 2];
      width_arr[i] = req_width[2*i +: 2];
      data_arr[i]  = req_data[64*i +: 64];
    end
  end

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign accept   = found && ((state_q == EMPTY) || rsp_ready);
  assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  hada_op_unit u_op_unit (
    .op     (op_arr[grant]),
    .width  (width_arr[grant]),
    .data   (data_arr[grant]),
    .result (op_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (accept) begin
      rr_ptr   <= ptr_next;
      rsp_id   <= grant;
      rsp_data <= op_result;
    end
  end

  assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_hada_op_arbiter.sv
// Scoreboard bench for hada_op_arbiter: a pre-edge monitor models arbitration
// and operator results arithmetically and checks every response and grant.
module tb_hada_op_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [2*NREQ-1:0]   req_width;
  logic [64*NREQ-1:0]  req_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [63:0]         rsp_data;

  hada_op_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_width (req_width),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   ptr;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics from plain signed arithmetic at the selected width.
  function automatic logic [63:0] ref_op(input int op, input int w, input logic [63:0] d);
    int     sh;
    longint s;
    longint a;
    sh = 64 - (8 << w);
    s  = longint'(d << sh) >>> sh;
    case (op)
      0: begin
        a = (s < 0) ? -s : s;
        a = (a << sh) >>> sh;
        return a;
      end
      1: return (s > 0) ? 64'd1 : ((s < 0) ? '1 : 64'd0);
      2: return ((d << sh) != 64'd0) ? 64'd1 : 64'd0;
      default: return s;
    endcase
  endfunction

  task automatic set_req(input int i, input int op, input int w, input logic [63:0] d);
    req_op[2*i +: 2]    = 2'(op);
    req_width[2*i +: 2] = 2'(w);
    req_data[64*i +: 64] = d;
  endtask

  task automatic rand_fields();
    logic [63:0] d;
    for (int i = 0; i < NREQ; i++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: d = 64'd0;
        1: d = 64'h80 << (8 * $urandom_range(0, 7));
        default: ;
      endcase
      set_req(i, $urandom_range(0, 3), $urandom_range(0, 3), d);
    end
  endtask

  // Pre-edge monitor: scoreboard pop on drain, model grant and push on accept.
  bit          m_full;
  bit          m_any;
  bit          m_acc;
  int          m_g;
  int          m_idx;
  logic [NREQ-1:0] m_rdy;
  exp_t        m_e;

  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      m_full = (sb.size() != 0);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
      if (m_full) begin
        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        chk("rsp_data", rsp_data, sb[0].data);
      end
      m_any = 1'b0;
      m_g   = 0;
      for (int k = 0; k < NREQ; k++) begin
        m_idx = (ptr + k) % NREQ;
        if (!m_any && req_valid[m_idx]) begin
          m_any = 1'b1;
          m_g   = m_idx;
        end
      end
      m_acc = m_any && (!m_full || rsp_ready);
      m_rdy = '0;
      if (m_acc) m_rdy[m_g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(m_rdy));
      if (m_full && rsp_ready) void'(sb.pop_front());
      if (m_acc) begin
        m_e.id   = m_g;
        m_e.data = ref_op(int'(req_op[2*m_g +: 2]), int'(req_width[2*m_g +: 2]),
                          req_data[64*m_g +: 64]);
        sb.push_back(m_e);
        ptr = (m_g + 1) % NREQ;
        grant_log.push_back(m_g);
      end
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    req_valid = '0;
    #1 rst_n = 1'b0;
    sb.delete();
    ptr = 0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_one(input int i, input int op, input int w, input logic [63:0] d,
                        input logic [63:0] exp, input string name);
    @(negedge clk);
    set_req(i, op, w, d);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    rsp_ready    = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({name, "_id"}, 64'(rsp_id), 64'(i));
    chk({name, "_data"}, rsp_data, exp);
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ptr   = 0;
    rst_n = 1'b0;
    req_op = '0;
    req_width = '0;
    req_data = '0;
    req_valid = '0;
    set_req(0, 0, 0, 64'hFB);
    req_valid[0] = 1'b1;
    rsp_ready = 1'b1;
    #2;
    chk("init_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("init_rsp_id", 64'(rsp_id), 64'd0);
    chk("init_rsp_data", rsp_data, 64'd0);

    // First accept on the first edge after reset release.
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abs_fb_valid", 64'(rsp_valid), 64'd1);
    chk("abs_fb_id", 64'(rsp_id), 64'd0);
    chk("abs_fb_data", rsp_data, 64'd5);
    @(negedge clk);
    req_valid = '0;

    // All requesters valid, consumer always ready: strict rotation.
    reset_pulse();
    grant_log.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rand_fields();
      req_valid = '1;
      rsp_ready = 1'b1;
    end

    // Stall while FULL, then drain and refill in one cycle.
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rr_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i),
          64'((i < grant_log.size()) ? grant_log[i] : 99), 64'(exp_g[i]));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data", rsp_data, (sb.size() != 0) ? sb[0].data : ~rsp_data);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("refill_onehot", 64'($countones(req_ready)), 64'd1);
    @(posedge clk);
    #1;
    chk("refill_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    req_valid = '0;

    // Boundary values.
    do_one(1, 0, 0, 64'h1234_5678_0000_0080, 64'hFFFF_FFFF_FFFF_FF80, "abs8_min");
    do_one(3, 1, 1, 64'hFFFF_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FFFF, "signum16_neg");
    do_one(0, 2, 3, 64'h0, 64'h0, "signumu64_zero");
    do_one(2, 3, 2, 64'h1_8000_0000, 64'hFFFF_FFFF_8000_0000, "cons32");
    do_one(1, 2, 0, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, "signumu8_hi_ignored");

    // Lone requester 2 with rr_ptr at 3.
    reset_pulse();
    do_one(2, 0, 0, 64'h03, 64'd3, "ptr_setup");
    @(negedge clk);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("lone_req2_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = 4'b1100;
    #1;
    chk("ptr_kept_at3", 64'(req_ready), 64'b1000);
    @(negedge clk);
    req_valid = '0;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rand_fields();
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("drained", 64'(sb.size()), 64'd0);

    // Reset while FULL discards the held result.
    @(negedge clk);
    set_req(3, 3, 3, 64'hDEAD_BEEF_0000_0001);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_full", 64'(rsp_valid), 64'd1);
    reset_pulse();
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_idle", 64'(rsp_valid), 64'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
